// File: rtl/mips150_io_pkg.sv
// Shared constants and types for the MIPS150 memory-mapped I/O controller.
package mips150_io_pkg;

  // Word offsets decoded from io_addr[5:2]
  localparam logic [3:0] OFF_TX_STATUS = 4'h0;
  localparam logic [3:0] OFF_RX_STATUS = 4'h1;
  localparam logic [3:0] OFF_TX_DATA   = 4'h2;
  localparam logic [3:0] OFF_RX_DATA   = 4'h3;
  localparam logic [3:0] OFF_CYCLES    = 4'h4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

  function automatic int unsigned baudCntWidth(input int unsigned cycles);
    return (cycles <= 1) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/mips150_io_ctrl_if.sv
// X-stage IO store/load strobes from the core and the registered M-stage load data.
interface mips150_io_ctrl_if;
  logic [3:0]  io_we;
  logic        io_re;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;

  modport master (output io_we, io_re, io_addr, io_wdata, input io_rdata);
  modport slave  (input io_we, io_re, io_addr, io_wdata, output io_rdata);
endinterface

// File: rtl/mips150_io_ctrl_uart.sv
// Full-duplex 8N1 UART: TX/RX state machines, RX synchroniser and a one-byte RX buffer.
module io_uart
  import mips150_io_pkg::*;
#(
  parameter int unsigned SYMBOL_EDGE_TIME = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       serial_out,
  input  logic       serial_in,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_pop,
  output logic       rx_overrun
);

  localparam int unsigned BAUD_W = baudCntWidth(SYMBOL_EDGE_TIME);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(SYMBOL_EDGE_TIME - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(SYMBOL_EDGE_TIME / 2 - 1);

  txState_t          txState, txStateNext;
  logic [BAUD_W-1:0] txBaud, txBaudNext;
  logic [2:0]        txBit, txBitNext;
  logic [7:0]        txShift, txShiftNext;
  logic              serialOutNext;

  rxState_t          rxState, rxStateNext;
  logic [BAUD_W-1:0] rxBaud, rxBaudNext;
  logic [2:0]        rxBit, rxBitNext;
  logic [7:0]        rxShift, rxShiftNext;
  logic [1:0]        rxSync;
  logic              rxPrev;
  logic              rxd;
  logic              rxDone_c;
  logic [7:0]        rxByte, rxByteNext;
  logic              rxValid, rxValidNext;
  logic              rxOverrun, rxOverrunNext;

  assign rxd        = rxSync[1];
  assign tx_ready   = (txState == TX_IDLE);
  assign rx_valid   = rxValid;
  assign rx_data    = rxByte;
  assign rx_overrun = rxOverrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txState    <= TX_IDLE;
      txBaud     <= '0;
      txBit      <= '0;
      txShift    <= '0;
      serial_out <= 1'b1;
      rxState    <= RX_IDLE;
      rxBaud     <= '0;
      rxBit      <= '0;
      rxShift    <= '0;
      rxSync     <= 2'b11;
      rxPrev     <= 1'b1;
      rxByte     <= '0;
      rxValid    <= 1'b0;
      rxOverrun  <= 1'b0;
    end else begin
      txState    <= txStateNext;
      txBaud     <= txBaudNext;
      txBit      <= txBitNext;
      txShift    <= txShiftNext;
      serial_out <= serialOutNext;
      rxState    <= rxStateNext;
      rxBaud     <= rxBaudNext;
      rxBit      <= rxBitNext;
      rxShift    <= rxShiftNext;
      rxSync     <= {rxSync[0], serial_in};
      rxPrev     <= rxd;
      rxByte     <= rxByteNext;
      rxValid    <= rxValidNext;
      rxOverrun  <= rxOverrunNext;
    end
  end

  // serial_out is registered from the current state, so the line trails the state by one cycle
  always_comb begin
    txStateNext   = txState;
    txBaudNext    = txBaud;
    txBitNext     = txBit;
    txShiftNext   = txShift;
    serialOutNext = 1'b1;
    case (txState)
      TX_IDLE: begin
        if (tx_valid) begin
          txStateNext = TX_START;
          txBaudNext  = '0;
          txBitNext   = '0;
          txShiftNext = tx_data;
        end
      end
      TX_START: begin
        serialOutNext = 1'b0;
        if (txBaud == BAUD_LAST) begin
          txBaudNext  = '0;
          txStateNext = TX_DATA;
        end else begin
          txBaudNext = txBaud + BAUD_W'(1);
        end
      end
      TX_DATA: begin
        serialOutNext = txShift[txBit];
        if (txBaud == BAUD_LAST) begin
          txBaudNext = '0;
          if (txBit == 3'd7) txStateNext = TX_STOP;
          else               txBitNext   = txBit + 3'd1;
        end else begin
          txBaudNext = txBaud + BAUD_W'(1);
        end
      end
      TX_STOP: begin
        if (txBaud == BAUD_LAST) begin
          txBaudNext  = '0;
          txStateNext = TX_IDLE;
        end else begin
          txBaudNext = txBaud + BAUD_W'(1);
        end
      end
      default: txStateNext = TX_IDLE;
    endcase
  end

  // Start bit is re-checked at half a bit; data and stop are sampled a full bit apart
  always_comb begin
    rxStateNext = rxState;
    rxBaudNext  = rxBaud;
    rxBitNext   = rxBit;
    rxShiftNext = rxShift;
    rxDone_c    = 1'b0;
    case (rxState)
      RX_IDLE: begin
        if (rxPrev && !rxd) begin
          rxStateNext = RX_START;
          rxBaudNext  = '0;
        end
      end
      RX_START: begin
        if (rxBaud == BAUD_HALF) begin
          rxBaudNext  = '0;
          rxBitNext   = '0;
          rxStateNext = rxd ? RX_IDLE : RX_DATA;
        end else begin
          rxBaudNext = rxBaud + BAUD_W'(1);
        end
      end
      RX_DATA: begin
        if (rxBaud == BAUD_LAST) begin
          rxBaudNext  = '0;
          rxShiftNext = {rxd, rxShift[7:1]};
          if (rxBit == 3'd7) rxStateNext = RX_STOP;
          else               rxBitNext   = rxBit + 3'd1;
        end else begin
          rxBaudNext = rxBaud + BAUD_W'(1);
        end
      end
      RX_STOP: begin
        if (rxBaud == BAUD_LAST) begin
          rxBaudNext  = '0;
          rxStateNext = RX_IDLE;
          rxDone_c    = rxd;
        end else begin
          rxBaudNext = rxBaud + BAUD_W'(1);
        end
      end
      default: rxStateNext = RX_IDLE;
    endcase
  end

  // A pop coinciding with completion keeps the new byte valid but clears any overrun
  always_comb begin
    rxByteNext    = rxByte;
    rxValidNext   = rxValid;
    rxOverrunNext = rxOverrun;
    if (rxDone_c) begin
      rxByteNext    = rxShift;
      rxValidNext   = 1'b1;
      rxOverrunNext = rx_pop ? 1'b0 : (rxOverrun | rxValid);
    end else if (rx_pop) begin
      rxValidNext   = 1'b0;
      rxOverrunNext = 1'b0;
    end
  end

endmodule

// File: rtl/mips150_io_ctrl.sv
// MIPS150 IO region: address decode, UART register file, cycle counter and registered load mux.
module mips150_io_ctrl
  import mips150_io_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic               clk,
  input  logic               rst,
  mips150_io_ctrl_if.slave   bus,
  input  logic               serial_in,
  output logic               serial_out
);

  localparam int unsigned SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;

  logic [3:0]  off;
  logic        wr;
  logic        txValid_c;
  logic        txReady;
  logic        rxValid;
  logic        rxOverrun;
  logic [7:0]  rxData;
  logic        rxPop_c;
  logic        cntClr_c;
  logic [31:0] cycleCount;
  logic [31:0] rdataNext;
  logic        unusedBits;

  assign off       = bus.io_addr[5:2];
  assign wr        = |bus.io_we;
  assign txValid_c = wr && (off == OFF_TX_DATA);
  assign cntClr_c  = wr && (off == OFF_CYCLES);
  assign rxPop_c   = bus.io_re && (off == OFF_RX_DATA);
  assign unusedBits = ^{bus.io_addr[31:6], bus.io_addr[1:0], bus.io_wdata[31:8]};

  io_uart #(
    .SYMBOL_EDGE_TIME(SYMBOL_EDGE_TIME)
  ) uart (
    .clk        (clk),
    .rst        (rst),
    .tx_valid   (txValid_c),
    .tx_data    (bus.io_wdata[7:0]),
    .tx_ready   (txReady),
    .serial_out (serial_out),
    .serial_in  (serial_in),
    .rx_valid   (rxValid),
    .rx_data    (rxData),
    .rx_pop     (rxPop_c),
    .rx_overrun (rxOverrun)
  );

  // Free-running counter; a write in the same cycle wins over the increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cycleCount <= '0;
    else if (cntClr_c) cycleCount <= '0;
    else               cycleCount <= cycleCount + 32'd1;
  end

  always_comb begin
    rdataNext = '0;
    case (off)
      OFF_TX_STATUS: rdataNext = {31'd0, txReady};
      OFF_RX_STATUS: rdataNext = {30'd0, rxOverrun, rxValid};
      OFF_RX_DATA:   rdataNext = {24'd0, rxData};
      OFF_CYCLES:    rdataNext = cycleCount;
      default:       rdataNext = '0;
    endcase
  end

  // Load data only updates on a load so the M stage sees a stable value otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             bus.io_rdata <= '0;
    else if (bus.io_re)  bus.io_rdata <= rdataNext;
  end

endmodule

// File: tb/tb_mips150_io_ctrl.sv
// Directed bench for mips150_io_ctrl at 10 cycles per UART bit.
module tb_mips150_io_ctrl;

  localparam int unsigned CLOCK_FREQ = 1000;
  localparam int unsigned BAUD_RATE  = 100;
  localparam int unsigned SET        = CLOCK_FREQ / BAUD_RATE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic serial_in = 1'b1;
  logic serial_out;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] rd;

  mips150_io_ctrl_if bus();

  mips150_io_ctrl #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .serial_in (serial_in),
    .serial_out(serial_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic busWrite(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.io_we    = we;
    bus.io_addr  = addr;
    bus.io_wdata = data;
    @(negedge clk);
    bus.io_we    = 4'h0;
  endtask

  task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus.io_re   = 1'b1;
    bus.io_addr = addr;
    @(negedge clk);
    bus.io_re   = 1'b0;
    data = bus.io_rdata;
  endtask

  // Called right after the TX write's accepting edge; checks every cycle of the frame
  task automatic txFrameCheck(input logic [7:0] b, input string tag);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 41) begin
        bus.io_re = 1'b0;
        check($sformatf("%s_midframe_status", tag), bus.io_rdata, 32'h0);
      end
      if (i == 40) begin
        bus.io_re   = 1'b1;
        bus.io_addr = 32'h00;
      end
      check($sformatf("%s_bit%0d_cyc%0d", tag, i / 10, i), 32'(serial_out), 32'(frame[i / 10]));
    end
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic stopBit);
    logic [9:0] frame;
    frame = {stopBit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      serial_in = frame[i];
      repeat (SET) @(negedge clk);
    end
    serial_in = 1'b1;
    repeat (SET) @(negedge clk);
  endtask

  initial begin
    bus.io_we    = 4'h0;
    bus.io_re    = 1'b0;
    bus.io_addr  = 32'h0;
    bus.io_wdata = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("reset_serial_out", 32'(serial_out), 32'h1);
    check("reset_rdata", bus.io_rdata, 32'h0);
    busRead(32'h00, rd); check("reset_tx_status", rd, 32'h1);
    busRead(32'h14, rd); check("unmapped_read", rd, 32'h0);
    busRead(32'h04, rd); check("reset_rx_status", rd, 32'h0);
    busRead(32'h0C, rd); check("reset_rx_data", rd, 32'h0);

    // TX frame 0xA5
    busWrite(4'hF, 32'h08, 32'h0000_00A5);
    txFrameCheck(8'hA5, "tx1");
    busRead(32'h00, rd); check("tx1_ready_after", rd, 32'h1);
    repeat (3) @(negedge clk);
    check("rdata_hold", bus.io_rdata, 32'h1);

    // Single RX frame
    sendFrame(8'h3C, 1'b1);
    busRead(32'h04, rd); check("rx1_status", rd, 32'h1);
    busRead(32'h0C, rd); check("rx1_data", rd, 32'h3C);
    busRead(32'h04, rd); check("rx1_status_cleared", rd, 32'h0);

    // Overrun
    sendFrame(8'h11, 1'b1);
    sendFrame(8'h22, 1'b1);
    busRead(32'h04, rd); check("ovr_status", rd, 32'h3);
    busRead(32'h0C, rd); check("ovr_data", rd, 32'h22);
    busRead(32'h04, rd); check("ovr_status_cleared", rd, 32'h0);

    // Framing error and start-bit glitch
    sendFrame(8'h55, 1'b0);
    busRead(32'h04, rd); check("framing_err_status", rd, 32'h0);
    serial_in = 1'b0;
    repeat (3) @(negedge clk);
    serial_in = 1'b1;
    repeat (30) @(negedge clk);
    busRead(32'h04, rd); check("glitch_status", rd, 32'h0);
    sendFrame(8'h81, 1'b1);
    busRead(32'h04, rd); check("rx_recover_status", rd, 32'h1);
    busRead(32'h0C, rd); check("rx_recover_data", rd, 32'h81);

    // Cycle counter clear and read
    busWrite(4'hF, 32'h10, 32'hDEAD_BEEF);
    repeat (4) @(negedge clk);
    busRead(32'h10, rd); check("cnt_after_clear", rd, 32'd5);

    // Counter wrap
    @(negedge clk);
    force dut.cycleCount = 32'hFFFF_FFFF;
    bus.io_re   = 1'b1;
    bus.io_addr = 32'h10;
    #1 release dut.cycleCount;
    @(negedge clk);
    check("cnt_max", bus.io_rdata, 32'hFFFF_FFFF);
    @(negedge clk);
    bus.io_re = 1'b0;
    check("cnt_wrap", bus.io_rdata, 32'h0);

    // Reset in the middle of a frame of zeros
    busRead(32'h10, rd);
    busWrite(4'hF, 32'h08, 32'h0000_0000);
    repeat (30) @(negedge clk);
    check("pre_reset_line_low", 32'(serial_out), 32'h0);
    #2 rst = 1'b1;
    #1;
    check("async_reset_serial_out", 32'(serial_out), 32'h1);
    check("async_reset_rdata", bus.io_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    busRead(32'h10, rd); check("cnt_after_reset", rd, 32'd1);
    busRead(32'h00, rd); check("tx_ready_after_reset", rd, 32'h1);
    busWrite(4'h1, 32'h08, 32'h1234_56A5);
    check("tx2_idle_before_start", 32'(serial_out), 32'h1);
    txFrameCheck(8'hA5, "tx2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
